// File: rtl/clkdiv_rr_mux.sv
// Programmable clock divider that captures one of NCH channels into `out` on every
// divided-clock toggle, round-robin. Optional `hold` input via CLKDIV_HOLD_EN.
module clkdiv_rr_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
`ifdef CLKDIV_HOLD_EN
  input  logic                                        hold,
`endif
  input  logic [CNT_W-1:0]                            half_per,
  input  logic [NCH*WIDTH-1:0]                        din,
  output logic                                        clk_out,
  output logic                                        edge_stb,
  output logic [((NCH > 2) ? $clog2(NCH) : 1)-1:0]    ch_idx,
  output logic [WIDTH-1:0]                            out
);

  localparam int unsigned IDX_W = (NCH > 2) ? $clog2(NCH) : 1;

  if (NCH < 2 || NCH > 16) begin : g_nch_range
    $error("clkdiv_rr_mux: NCH must be within 2..16");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ch_idx_q, ch_idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             clk_out_q, clk_out_d;
  logic             edge_stb_q, edge_stb_d;

  logic [CNT_W-1:0] half_eff_c;
  logic             run_c;
  logic             term_c;
  logic [WIDTH-1:0] chan_c;

  // A programmed half-period of 0 behaves as 1.
  assign half_eff_c = (half_per == '0) ? CNT_W'(1) : half_per;

`ifdef CLKDIV_HOLD_EN
  assign run_c = ~hold;
`else
  assign run_c = 1'b1;
`endif

  assign term_c = (cnt_q == (half_q - CNT_W'(1)));
  assign chan_c = din[int'(ptr_q)*WIDTH +: WIDTH];

  // Next-state: count up, or toggle and capture the next channel at the terminal count.
  always_comb begin
    cnt_d      = cnt_q;
    half_d     = half_q;
    ptr_d      = ptr_q;
    ch_idx_d   = ch_idx_q;
    out_d      = out_q;
    clk_out_d  = clk_out_q;
    edge_stb_d = 1'b0;
    if (run_c) begin
      if (term_c) begin
        clk_out_d  = ~clk_out_q;
        edge_stb_d = 1'b1;
        out_d      = chan_c;
        ch_idx_d   = ptr_q;
        ptr_d      = (ptr_q == IDX_W'(NCH - 1)) ? '0 : ptr_q + IDX_W'(1);
        cnt_d      = '0;
        half_d     = half_eff_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      half_q     <= half_eff_c;
      ptr_q      <= '0;
      ch_idx_q   <= '0;
      out_q      <= '0;
      clk_out_q  <= 1'b0;
      edge_stb_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      ptr_q      <= ptr_d;
      ch_idx_q   <= ch_idx_d;
      out_q      <= out_d;
      clk_out_q  <= clk_out_d;
      edge_stb_q <= edge_stb_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign edge_stb = edge_stb_q;
  assign ch_idx   = ch_idx_q;
  assign out      = out_q;

endmodule

// File: tb/tb_clkdiv_rr_mux.sv
// Bench for clkdiv_rr_mux: two instances (NCH=2 and NCH=3) checked every cycle
// against a toggle-count model, plus directed literal expectations.
module tb_clkdiv_rr_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold_v = 1'b0;
  logic [7:0]  hp2 = 8'd1;
  logic [3:0]  hp3 = 4'd3;
  logic [15:0] din2 = '0;
  logic [23:0] din3 = '0;

  logic        clk_out2, stb2, idx2;
  logic [7:0]  out2;
  logic        clk_out3, stb3;
  logic [1:0]  idx3;
  logic [7:0]  out3;

  int n_checks = 0;
  int n_fail   = 0;
  bit valid    = 1'b0;

  always #5 clk = ~clk;

  clkdiv_rr_mux #(.WIDTH(8), .NCH(2), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset),
`ifdef CLKDIV_HOLD_EN
    .hold(hold_v),
`endif
    .half_per(hp2), .din(din2),
    .clk_out(clk_out2), .edge_stb(stb2), .ch_idx(idx2), .out(out2)
  );

  clkdiv_rr_mux #(.WIDTH(8), .NCH(3), .CNT_W(4)) u3 (
    .clk(clk), .reset(reset),
`ifdef CLKDIV_HOLD_EN
    .hold(hold_v),
`endif
    .half_per(hp3), .din(din3),
    .clk_out(clk_out3), .edge_stb(stb3), .ch_idx(idx3), .out(out3)
  );

  typedef struct {
    int toggles;
    int elapsed;
    int half;
    int outv;
    int idx;
    bit stb;
  } model_t;

  model_t m2, m3;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clk edge of the reference: count elapsed cycles, toggle when a half-period completes.
  function automatic model_t step(input model_t m, input bit rst, input bit hld,
                                  input int hp, input int nch, input logic [127:0] dinv);
    model_t r;
    int e;
    logic [127:0] sh;
    r = m;
    e = (hp == 0) ? 1 : hp;
    r.stb = 1'b0;
    if (rst) begin
      r.toggles = 0; r.elapsed = 0; r.half = e; r.outv = 0; r.idx = 0;
    end else if (!hld) begin
      r.elapsed++;
      if (r.elapsed == r.half) begin
        r.idx = r.toggles % nch;
        sh = dinv >> (r.idx * 8);
        r.outv = int'(sh[7:0]);
        r.toggles++;
        r.stb = 1'b1;
        r.elapsed = 0;
        r.half = e;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m2 = step(m2, reset, hold_v, int'(hp2), 2, 128'(din2));
    m3 = step(m3, reset, hold_v, int'(hp3), 3, 128'(din3));
    if (reset) valid = 1'b1;
    #1;
    if (valid) begin
      check("u2.clk_out",  int'(clk_out2), m2.toggles % 2);
      check("u2.edge_stb", int'(stb2),     int'(m2.stb));
      check("u2.ch_idx",   int'(idx2),     m2.idx);
      check("u2.out",      int'(out2),     m2.outv);
      check("u3.clk_out",  int'(clk_out3), m3.toggles % 2);
      check("u3.edge_stb", int'(stb3),     int'(m3.stb));
      check("u3.ch_idx",   int'(idx3),     m3.idx);
      check("u3.out",      int'(out3),     m3.outv);
    end
  end

  int exp_idx3 [4] = '{0, 1, 2, 0};
  int exp_out3 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hA1};

  initial begin
    m2 = '{default: 0};
    m3 = '{default: 0};
    din2 = {8'h5A, 8'hA5};
    din3 = {8'hC3, 8'hB2, 8'hA1};
    repeat (2) @(posedge clk);
    #2;
    check("rst.u2.clk_out", int'(clk_out2), 0);
    check("rst.u2.stb",     int'(stb2),     0);
    check("rst.u2.out",     int'(out2),     0);
    check("rst.u2.idx",     int'(idx2),     0);
    check("rst.u3.clk_out", int'(clk_out3), 0);
    check("rst.u3.stb",     int'(stb3),     0);
    check("rst.u3.out",     int'(out3),     0);
    check("rst.u3.idx",     int'(idx3),     0);

    @(negedge clk) reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #2;
      check("dir.u2.out",     int'(out2),     (e % 2 == 1) ? 8'hA5 : 8'h5A);
      check("dir.u2.clk_out", int'(clk_out2), (e % 2 == 1) ? 1 : 0);
      check("dir.u2.stb",     int'(stb2),     1);
      check("dir.u3.stb",     int'(stb3),     (e % 3 == 0) ? 1 : 0);
      if (e % 3 == 0) begin
        check("dir.u3.idx",     int'(idx3),     exp_idx3[e/3 - 1]);
        check("dir.u3.out",     int'(out3),     exp_out3[e/3 - 1]);
        check("dir.u3.clk_out", int'(clk_out3), (e/3) % 2);
      end
    end

    // Reset one cycle ahead of the toggle that would land on edge 15.
    repeat (2) @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #2;
    check("rst2.u3.clk_out", int'(clk_out3), 0);
    check("rst2.u3.stb",     int'(stb3),     0);
    check("rst2.u3.out",     int'(out3),     0);
    check("rst2.u3.idx",     int'(idx3),     0);
    @(negedge clk) reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
      check("rst2.u3.nostb", int'(stb3), 0);
    end
    @(posedge clk);
    #2;
    check("rst2.u3.stb1",    int'(stb3),     1);
    check("rst2.u3.idx1",    int'(idx3),     0);
    check("rst2.u3.out1",    int'(out3),     8'hA1);
    check("rst2.u3.clk_out1", int'(clk_out3), 1);

    // Half-period change 2 -> 5 partway through a half-period.
    @(negedge clk) begin reset = 1'b1; hp3 = 4'd2; end
    @(negedge clk) reset = 1'b0;
    @(negedge clk) hp3 = 4'd5;
    repeat (24) @(negedge clk);

    // Randomised phase: resets, ratio changes (incl. 0 and max), noisy data.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom % 50 == 0);
      if ($urandom % 16 == 0) hp2 = ($urandom % 8 == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      if ($urandom % 12 == 0) hp3 = 4'($urandom_range(0, 15));
      din2 = 16'($urandom);
      din3 = 24'($urandom);
`ifdef CLKDIV_HOLD_EN
      hold_v = ($urandom % 6 == 0);
`endif
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_rr_mux.md
# clkdiv_rr_mux

Parametrised successor to the team's divide-by-2 alternate-edge selector. It divides `clk` by a runtime-programmable ratio and produces a divided clock. On every toggle of that divided clock, rising or falling, it registers the next of NCH data channels into `out` in round-robin order. Everything runs in the single `clk` domain: there is no derived-clock logic and no negedge logic. With NCH=2 and `half_per`=1, `out` alternates channel 0 and channel 1 on successive `clk` edges, and channel 0 is taken on each rising edge of `clk_out`.

## Interface
Parameters:
- `WIDTH`, 8, data width per channel.
- `NCH`, 2, number of input channels; legal range 2..16.
- `CNT_W`, 8, width of the half-period counter and of `half_per`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `half_per`  in  CNT_W  half-period of `clk_out`, in `clk` cycles; 0 is treated as 1.
- `din`  in  NCH*WIDTH  packed channels; channel k occupies `din[k*WIDTH +: WIDTH]`.
- `clk_out`  out  1  divided clock, registered.
- `edge_stb`  out  1  one-cycle pulse in the cycle `clk_out` changes.
- `ch_idx`  out  max(1,$clog2(NCH))  index of the channel currently held in `out`.
- `out`  out  WIDTH  registered selected data.

## Operation
- Internal state:
  - `cnt` (CNT_W): half-period counter.
  - `half_q` (CNT_W): latched effective half-period.
  - `ptr`: next channel to capture.
- Reset (checked every edge, highest priority):
  - `clk_out`=0, `edge_stb`=0, `out`=0, `ch_idx`=0, `ptr`=0, `cnt`=0.
  - `half_q` loads the effective value of `half_per` (0 becomes 1).
- Normal cycle, with `cnt` != `half_q`-1:
  - `cnt`++.
  - `edge_stb`=0.
  - All other state holds.
- Terminal cycle, with `cnt` == `half_q`-1:
  - `clk_out` <= ~`clk_out`.
  - `edge_stb` <= 1.
  - `out` <= channel `ptr`.
  - `ch_idx` <= `ptr`.
  - `ptr` <= (`ptr`==NCH-1) ? 0 : `ptr`+1.
  - `cnt` <= 0.
  - `half_q` <= effective `half_per`.
- Ratio changes take effect only at a toggle boundary, so a half-period is never truncated or stretched mid-count.
- Period of `clk_out` = 2*`half_q` cycles.
  - Duty cycle is exactly 50% while `half_per` is stable.
  - A change shifts only the half-periods that start after the next toggle.
- Channel sequence is strictly 0,1,…,NCH-1,0,…
  - With even NCH, each channel is always captured on the same `clk_out` polarity.
  - With odd NCH, a channel alternates between rising-edge and falling-edge capture on successive passes.
- `din` is sampled only in the terminal cycle. Changes at other times have no effect.

## Timing
- Latency: `out`, `ch_idx`, `clk_out` and `edge_stb` all update on the same `clk` edge, one edge after the terminal-cycle condition is met. They are never skewed relative to each other.
- After reset deasserts, the first toggle (`clk_out` 0→1, capturing channel 0) happens on the `half_q`-th rising edge.
- `half_q`=1: `clk_out` toggles every cycle, and `edge_stb` stays high continuously.
- `half_per` at its maximum value (2^CNT_W−1): `cnt` reaches 2^CNT_W−2, then wraps to 0 with no overflow.
- Reset asserted mid-period: state is abandoned on that edge. No `edge_stb` is produced in the reset cycle.

## Configuration
- `CLKDIV_HOLD_EN` defined:
  - Adds input port `hold` (1 bit).
  - While `hold`=1 and `reset`=0: `cnt`, `clk_out`, `ptr`, `out`, `ch_idx` and `half_q` freeze, and `edge_stb`=0.
  - Counting resumes from the frozen `cnt` when `hold` drops.
  - `reset` overrides `hold`.
- `CLKDIV_HOLD_EN` not defined: no `hold` port, and the block free-runs whenever it is out of reset.

## Test plan
- NCH=2, WIDTH=8, `half_per`=1, ch0=8'hA5, ch1=8'h5A, release reset → `clk_out` toggles every cycle; `out` = A5, 5A, A5, … starting on the first edge, with A5 always on the rising edge of `clk_out`; `edge_stb` stays high.
- NCH=3, `half_per`=3 → `clk_out` period is 6 cycles; `ch_idx` = 0,1,2,0 on edges 3, 6, 9, 12; `edge_stb` pulses only on those edges.
- `half_per` changed from 2 to 5 mid-half-period → the current half-period completes at 2 cycles; every later half-period is 5 cycles.
- `half_per`=0 → behaves exactly as `half_per`=1.
- Reset pulsed one cycle before an expected toggle → on the next edge all outputs are 0; the first post-reset toggle captures channel 0 after `half_q` cycles.
- With `CLKDIV_HOLD_EN`: `hold` high for 4 cycles mid-count (`half_per`=4, `cnt`=2) → no toggle during the hold; the toggle lands 2 cycles after `hold` drops.
